// File: rtl/mtf_pkg.sv
// Shared types and constants for the move-to-front decoder and encoder.
// Statistics counters are built only when MTF_DEC_STATS_EN is defined.
package mtf_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 4;

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned IDX_W_DEF = idx_w(DEPTH_DEF);

    typedef struct packed {
        logic                  is_lit;
        logic [IDX_W_DEF-1:0]  idx;
        logic [DATA_W_DEF-1:0] data;
    } mtf_tok_t;

endpackage

// File: rtl/mtf_list.sv
// Recency list storage with move-to-front, duplicate removal and eviction.
// Shared by the encoder and decoder so both ends update identically.
module mtf_list #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    update,
    input  logic [DATA_W-1:0]       value,
    input  logic                    hit,
    input  logic [IDX_W-1:0]        hit_pos,
    output logic [DEPTH*DATA_W-1:0] entries,
    output logic [DEPTH-1:0]        valid
);

    logic [DATA_W-1:0] ent_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            valid <= '0;
        end else if (update) begin
            ent_q[0] <= value;
            // On a hit only the entries in front of the hit slot move down.
            for (int k = 1; k < DEPTH; k++) begin
                if (!hit || k <= int'(hit_pos)) begin
                    ent_q[k] <= ent_q[k-1];
                end
            end
            if (!hit) begin
                valid <= {valid[DEPTH-2:0], 1'b1};
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign entries[g*DATA_W +: DATA_W] = ent_q[g];
    end

endmodule

// File: rtl/mtf_decoder.sv
// Move-to-front token decoder with registered output and sticky error flag.
// Define MTF_DEC_STATS_EN to build the literal/hit token counters.
module mtf_decoder
    import mtf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned IDX_W = idx_w(DEPTH)
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    input  logic              tok_valid_in,
    output logic              tok_ready_out,
    input  logic              tok_is_lit_in,
    input  logic [IDX_W-1:0]  tok_idx_in,
    input  logic [DATA_W-1:0] tok_data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    input  logic              data_ready_in,
    output logic              err_out,
    output logic [15:0]       lit_cnt_out,
    output logic [15:0]       hit_cnt_out
);

    logic [DEPTH*DATA_W-1:0] list_flat;
    logic [DEPTH-1:0]        list_valid;
    logic [DATA_W-1:0]       list_ent [DEPTH];

    logic              accept;
    logic              cam_hit;
    logic [IDX_W-1:0]  cam_pos;
    logic              idx_ok;
    logic              lst_update;
    logic              lst_hit;
    logic [IDX_W-1:0]  lst_pos;
    logic [DATA_W-1:0] lst_value;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            list_ent[k] = list_flat[k*DATA_W +: DATA_W];
        end
    end

    assign tok_ready_out = reset_n_in && (!data_valid_out || data_ready_in);
    assign accept        = tok_valid_in && tok_ready_out;

    // Valid entries are unique, so at most one slot can match.
    always_comb begin
        cam_hit = 1'b0;
        cam_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (list_valid[k] && list_ent[k] == tok_data_in) begin
                cam_hit = 1'b1;
                cam_pos = k[IDX_W-1:0];
            end
        end
    end

    assign idx_ok = list_valid[tok_idx_in];

    always_comb begin
        lst_value = tok_is_lit_in ? tok_data_in : list_ent[tok_idx_in];
        lst_hit   = tok_is_lit_in ? cam_hit : 1'b1;
        lst_pos   = tok_is_lit_in ? cam_pos : tok_idx_in;
    end

    assign lst_update = accept && (tok_is_lit_in || idx_ok);

    mtf_list #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_list (
        .clk     (clk_in),
        .rst_n   (reset_n_in),
        .update  (lst_update),
        .value   (lst_value),
        .hit     (lst_hit),
        .hit_pos (lst_pos),
        .entries (list_flat),
        .valid   (list_valid)
    );

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            if (lst_update) begin
                data_out       <= lst_value;
                data_valid_out <= 1'b1;
            end else if (data_ready_in) begin
                data_valid_out <= 1'b0;
            end
            if (accept && !tok_is_lit_in && !idx_ok) begin
                err_out <= 1'b1;
            end
        end
    end

`ifdef MTF_DEC_STATS_EN
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            lit_cnt_out <= '0;
            hit_cnt_out <= '0;
        end else begin
            if (accept && tok_is_lit_in && lit_cnt_out != 16'hFFFF) begin
                lit_cnt_out <= lit_cnt_out + 16'd1;
            end
            if (accept && !tok_is_lit_in && idx_ok && hit_cnt_out != 16'hFFFF) begin
                hit_cnt_out <= hit_cnt_out + 16'd1;
            end
        end
    end
`else
    assign lit_cnt_out = '0;
    assign hit_cnt_out = '0;
`endif

endmodule

// File: tb/tb_mtf_decoder.sv
// Self-checking bench for mtf_decoder: directed scenarios plus random tokens
// compared against a queue-based move-to-front reference model.
module tb_mtf_decoder;
    import mtf_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 8;

    logic              clk_in;
    logic              reset_n_in;
    logic              tok_valid_in;
    logic              tok_ready_out;
    logic              tok_is_lit_in;
    logic [1:0]        tok_idx_in;
    logic [7:0]        tok_data_in;
    logic [7:0]        data_out;
    logic              data_valid_out;
    logic              data_ready_in;
    logic              err_out;
    logic [15:0]       lit_cnt_out;
    logic [15:0]       hit_cnt_out;

    mtf_decoder #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_in         (clk_in),
        .reset_n_in     (reset_n_in),
        .tok_valid_in   (tok_valid_in),
        .tok_ready_out  (tok_ready_out),
        .tok_is_lit_in  (tok_is_lit_in),
        .tok_idx_in     (tok_idx_in),
        .tok_data_in    (tok_data_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .data_ready_in  (data_ready_in),
        .err_out        (err_out),
        .lit_cnt_out    (lit_cnt_out),
        .hit_cnt_out    (hit_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state: most recent value at the front of the queue.
    int   mlist[$];
    logic exp_valid;
    logic [7:0] exp_data;
    logic exp_err;
    int   exp_lit;
    int   exp_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mlist.delete();
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_err   = 1'b0;
        exp_lit   = 0;
        exp_hit   = 0;
    endtask

    task automatic model_token(input mtf_tok_t t, output logic emit, output logic [7:0] val);
        emit = 1'b0;
        val  = 8'h00;
        if (t.is_lit) begin
            foreach (mlist[j]) begin
                if (mlist[j] == int'(t.data)) begin
                    mlist.delete(j);
                    break;
                end
            end
            mlist.push_front(int'(t.data));
            if (mlist.size() > DEPTH) void'(mlist.pop_back());
            emit = 1'b1;
            val  = t.data;
            exp_lit++;
        end else if (int'(t.idx) < mlist.size()) begin
            val = 8'(mlist[t.idx]);
            mlist.delete(int'(t.idx));
            mlist.push_front(int'(val));
            emit = 1'b1;
            exp_hit++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    // Called just after a rising edge; applies one cycle of stimulus.
    task automatic cycle(input logic v, input mtf_tok_t t, input logic rdy);
        logic exp_ready, acc, emit;
        logic [7:0] val;
        tok_valid_in  = v;
        tok_is_lit_in = t.is_lit;
        tok_idx_in    = t.idx;
        tok_data_in   = t.data;
        data_ready_in = rdy;
        #1;
        exp_ready = !exp_valid || rdy;
        check("tok_ready", {31'd0, tok_ready_out}, {31'd0, exp_ready});
        acc = v && exp_ready;
        @(posedge clk_in);
        emit = 1'b0;
        if (acc) model_token(t, emit, val);
        if (emit) begin
            exp_valid = 1'b1;
            exp_data  = val;
        end else if (rdy) begin
            exp_valid = 1'b0;
        end
        #1;
        check("data_valid", {31'd0, data_valid_out}, {31'd0, exp_valid});
        if (exp_valid) check("data_out", {24'd0, data_out}, {24'd0, exp_data});
        check("err", {31'd0, err_out}, {31'd0, exp_err});
`ifdef MTF_DEC_STATS_EN
        check("lit_cnt", {16'd0, lit_cnt_out}, exp_lit);
        check("hit_cnt", {16'd0, hit_cnt_out}, exp_hit);
`else
        check("lit_cnt", {16'd0, lit_cnt_out}, 32'd0);
        check("hit_cnt", {16'd0, hit_cnt_out}, 32'd0);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        reset_n_in   = 1'b0;
        model_reset();
        #1;
        check("rst_ready", {31'd0, tok_ready_out}, 32'd0);
        check("rst_valid", {31'd0, data_valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_err", {31'd0, err_out}, 32'd0);
        check("rst_cnt", {lit_cnt_out, hit_cnt_out}, 32'd0);
        tok_valid_in = 1'b0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    function automatic mtf_tok_t lit(input logic [7:0] d);
        mtf_tok_t t;
        t.is_lit = 1'b1;
        t.idx    = 2'd0;
        t.data   = d;
        return t;
    endfunction

    function automatic mtf_tok_t idx(input logic [1:0] i);
        mtf_tok_t t;
        t.is_lit = 1'b0;
        t.idx    = i;
        t.data   = 8'($urandom_range(0, 255));
        return t;
    endfunction

    initial begin
        mtf_tok_t t;
        reset_n_in    = 1'b0;
        tok_valid_in  = 1'b0;
        tok_is_lit_in = 1'b0;
        tok_idx_in    = '0;
        tok_data_in   = '0;
        data_ready_in = 1'b1;
        model_reset();
        do_reset();

        // Literals, index recall and literal dedup.
        cycle(1'b1, lit(8'h11), 1'b1);
        cycle(1'b1, lit(8'h22), 1'b1);
        cycle(1'b1, lit(8'h33), 1'b1);
        cycle(1'b1, lit(8'h22), 1'b1);
        cycle(1'b1, idx(2'd3), 1'b1);
        cycle(1'b1, idx(2'd2), 1'b1);
        cycle(1'b1, idx(2'd0), 1'b1);
        cycle(1'b0, lit(8'h00), 1'b1);

        // Eviction of the oldest entry.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, lit(8'hA0 + 8'(k)), 1'b1);
        cycle(1'b1, idx(2'd3), 1'b1);
        cycle(1'b1, lit(8'hA0), 1'b1);
        cycle(1'b1, idx(2'd3), 1'b1);

        // Backpressure with a token waiting.
        cycle(1'b1, lit(8'h5A), 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b1, idx(2'd2), 1'b0);
        cycle(1'b1, idx(2'd2), 1'b1);
        cycle(1'b1, idx(2'd1), 1'b1);
        cycle(1'b0, lit(8'h00), 1'b1);

        // Invalid index raises the sticky error without emitting.
        do_reset();
        cycle(1'b1, lit(8'h55), 1'b1);
        cycle(1'b1, idx(2'd1), 1'b1);
        cycle(1'b0, lit(8'h00), 1'b1);
        cycle(1'b1, idx(2'd0), 1'b1);
        cycle(1'b1, idx(2'd2), 1'b0);
        cycle(1'b1, idx(2'd2), 1'b1);

        // Random traffic with a small value alphabet to exercise hits and dedup.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            t.is_lit = ($urandom_range(0, 99) < 55);
            t.idx    = 2'($urandom_range(0, 3));
            t.data   = 8'($urandom_range(0, 6));
            cycle($urandom_range(0, 99) < 80, t, $urandom_range(0, 99) < 70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mtf_decoder.md
# mtf_decoder

Move-to-front (MTF) decoder that turns a token stream of literals and recency indices back into the original data stream. It keeps a DEPTH-entry most-recently-used list and updates it exactly like the encoder-side recency buffer: a value moves to the front, duplicates are removed and the oldest entry is evicted. It sits at the receive end of the MTF-compressed link, between the token deserializer and the downstream data consumer.

## Interface
- DATA_W, 8, data word width
- DEPTH, 4, recency list entries; power of two, 2..16; IDX_W = $clog2(DEPTH) is a derived localparam
- clk_in  in  1  single clock, rising edge
- reset_n_in  in  1  asynchronous, active-low reset
- tok_valid_in  in  1  token present
- tok_ready_out  out  1  token accepted when tok_valid_in && tok_ready_out
- tok_is_lit_in  in  1  1 = literal token, 0 = index token
- tok_idx_in  in  IDX_W  list position for index tokens
- tok_data_in  in  DATA_W  literal value
- data_out  out  DATA_W  decoded word
- data_valid_out  out  1  data_out valid
- data_ready_in  in  1  consumer accepts data_out
- err_out  out  1  sticky error: an index token referenced an invalid entry
- lit_cnt_out  out  16  literal-token count (see Configuration)
- hit_cnt_out  out  16  index-token count (see Configuration)

## Operation
- List state: entry[0..DEPTH-1] with a valid bit each. entry[0] is the most recent entry.
- Acceptance: tok_ready_out = reset_n_in && (!data_valid_out || data_ready_in).
- Literal token, value v:
  - If a valid entry j holds v: entry[j] leaves its position, entries 0..j-1 shift down one place, and v goes to entry[0]. No eviction.
  - Otherwise all entries shift down one place, v goes to entry[0] and becomes valid, and entry[DEPTH-1] is dropped.
  - v is emitted.
- Index token, index i:
  - If entry[i] is valid: v = entry[i]. Entries 0..i-1 shift down one place and v goes to entry[0]. v is emitted. Index 0 leaves the list unchanged.
  - If entry[i] is invalid: the token is consumed, nothing is emitted, the list is unchanged and err_out is set.
- Update rule: the list update is identical to the encoder's rule, so both ends stay in lockstep.
- err_out: clears only on reset. It does not stall decoding.

## Timing
- Reset values:
  - All list valid bits 0 and list data 0.
  - data_out 0, data_valid_out 0, err_out 0, counters 0.
  - tok_ready_out 0 while reset is asserted.
- Latency: a token accepted at edge N gives data_valid_out high with data_out after edge N. The list update is visible to the token accepted at edge N+1, so back-to-back dependent tokens decode correctly.
- Throughput: 1 token/cycle while data_ready_in is high.
- Backpressure: while data_valid_out && !data_ready_in, data_out and data_valid_out hold, tok_ready_out is 0 and the list does not change.
- Output handshake: data_valid_out drops after a handshake cycle in which no new token is accepted.
- Error tokens: consumed in one cycle without touching data_valid_out, except the normal drop when the pending word is taken that cycle.
- Reset mid-stream: the list, the pending output and err_out clear immediately (asynchronously). An in-flight token is lost.
- Simultaneous events: an output handshake and a token acceptance in the same cycle replace data_out seamlessly.

## Configuration
- MTF_DEC_STATS_EN defined:
  - lit_cnt_out counts accepted literal tokens.
  - hit_cnt_out counts accepted valid index tokens.
  - Both are 16-bit, saturate at 0xFFFF and are reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure
- Package mtf_pkg holds:
  - mtf_tok_t struct (is_lit, idx, data), parameterised through localparams.
  - Default DEPTH and DATA_W constants.
  - clog2-based IDX_W helper.
- Sub-module mtf_list holds the recency storage plus the move-to-front/dedup/evict update. It takes inputs (update, value, hit, hit_pos) and exposes entries and valid bits. The encoder reuses the same sub-module so both list implementations are identical.
- mtf_decoder itself contains:
  - Token decode and the CAM compare on literals.
  - The output register and handshake.
  - The error flag and the optional counters.

## Test plan
All scenarios use DATA_W=8 and DEPTH=4.
- Reset, then literals 0x11, 0x22, 0x33 with data_ready_in=1 -> data_out 0x11, 0x22, 0x33 on consecutive cycles; list becomes [33,22,11,-].
- Continuing, index token 2 -> data_out 0x11; list becomes [11,33,22,-].
- Reset, then literals 0xA0..0xA4 -> list [A4,A3,A2,A1]; index 3 -> data_out 0xA1; 0xA0 is gone.
- Literal 0x22 while list is [33,22,11,-] -> data_out 0x22; list becomes [22,33,11,-] with exactly 3 valid entries.
- data_ready_in low for 3 cycles with tok_valid_in high -> tok_ready_out 0 and data_out held; after release, the outputs appear in order with no loss or duplication.
- Reset, literal 0x55, then index 1 -> no data_valid_out, err_out=1, list unchanged; a following index 0 -> 0x55. With MTF_DEC_STATS_EN: lit_cnt_out=1, hit_cnt_out=1.
